// File: rtl/button_conditioner.sv
// Per-button synchroniser, press/release debouncer and optional auto-repeat.
// Each channel emits a one-cycle press pulse; held tracks the debounced level.
module button_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 512,
  parameter int REPEAT_DELAY    = 5_000_000,
  parameter int REPEAT_PERIOD   = 2_000_000,
  parameter int CNT_W           = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] repeat_en,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] held,
  output logic               any_press
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    HOLD       = 3'd2,
    REPEAT     = 3'd3,
    DB_RELEASE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_BTN-1:0] press_next_all;
  logic               any_press_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi = gi + 1) begin : g_chan
      logic             sync1_reg;
      logic             sync2_reg;
      state_t           state_reg;
      state_t           state_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             press_reg;
      logic             press_next;
      logic             held_reg;
      logic             held_next;
      logic             s;

      assign s = sync2_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          state_reg <= IDLE;
          cnt_reg   <= '0;
          press_reg <= 1'b0;
          held_reg  <= 1'b0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          press_reg <= press_next;
          held_reg  <= held_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        press_next = 1'b0;
        held_next  = held_reg;
        case (state_reg)
          IDLE: begin
            if (s) begin
              state_next = DB_PRESS;
              cnt_next   = '0;
            end
          end
          DB_PRESS: begin
            if (!s) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else if (cnt_reg == DB_LAST) begin
              state_next = HOLD;
              cnt_next   = '0;
              press_next = 1'b1;
              held_next  = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
          HOLD: begin
            if (!s) begin
              state_next = DB_RELEASE;
              cnt_next   = '0;
            end else if (repeat_en[gi] && (cnt_reg == RD_LAST)) begin
              state_next = REPEAT;
              cnt_next   = '0;
              press_next = 1'b1;
            end else if (repeat_en[gi]) begin
              cnt_next = cnt_reg + CNT_ONE;
            end else begin
              // Delay restarts from scratch whenever repeat is re-enabled.
              cnt_next = '0;
            end
          end
          REPEAT: begin
            if (!s) begin
              state_next = DB_RELEASE;
              cnt_next   = '0;
            end else if (!repeat_en[gi]) begin
              state_next = HOLD;
              cnt_next   = '0;
            end else if (cnt_reg == RP_LAST) begin
              cnt_next   = '0;
              press_next = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
          DB_RELEASE: begin
            // A release glitch returns to HOLD silently: no second press.
            if (s) begin
              state_next = HOLD;
              cnt_next   = '0;
            end else if (cnt_reg == DB_LAST) begin
              state_next = IDLE;
              cnt_next   = '0;
              held_next  = 1'b0;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
          default: begin
            state_next = IDLE;
            cnt_next   = '0;
            held_next  = 1'b0;
          end
        endcase
      end

      assign press[gi]          = press_reg;
      assign held[gi]           = held_reg;
      assign press_next_all[gi] = press_next;
    end
  endgenerate

  // Registered from the next-state pulses so it lines up with press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_press_reg <= 1'b0;
    end else begin
      any_press_reg <= |press_next_all;
    end
  end

  assign any_press = any_press_reg;

endmodule
